// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: data width, opcodes, FSM states.
package pc_seq_pkg;

  localparam int DW = 8;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ALU  = 3'b001;
  localparam logic [2:0] OP_JMP  = 3'b010;
  localparam logic [2:0] OP_BZ   = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_OPERAND = 3'd3,
    ST_EXEC    = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

endpackage

// File: rtl/pc_seq_decode.sv
// Opcode to post-DECODE state map; purely combinational.
// Unassigned opcodes (100/101/110) fall back to NOP behaviour.
module pc_seq_decode
  import pc_seq_pkg::*;
(
  input  logic [2:0] opcode,
  output state_t     next_state
);

  always_comb begin
    next_state = ST_FETCH;
    case (opcode)
      OP_ALU:        next_state = ST_EXEC;
      OP_JMP, OP_BZ: next_state = ST_OPERAND;
      OP_HALT:       next_state = ST_HALT;
      default:       next_state = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode sequencer steering an external PC; NOP 2, ALU/JMP/BZ 3 cycles at zero wait.
// Memory waits stall in FETCH/OPERAND with the PC held so mem_addr stays stable.
module pc_sequencer
  import pc_seq_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] pc,
  input  logic          zero_flag,
  output logic          mem_req,
  output logic [DW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          power,
  output logic          stop_en,
  output logic          branch_en,
  output logic [DW-1:0] branch_pc,
  output logic [DW-1:0] ir,
  output logic          exec_valid,
  output logic          halted,
  output logic [2:0]    state
);

  state_t     st;
  state_t     dec_next;
  logic [2:0] op;
  logic       taken;

  assign op       = ir[7:5];
  assign mem_addr = pc;
  assign state    = st;
  // zero_flag only matters in the operand ack cycle, where it is consumed here
  assign taken    = (op == OP_JMP) || ((op == OP_BZ) && zero_flag);

  pc_seq_decode u_decode (
    .opcode     (op),
    .next_state (dec_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= ST_OFF;
      ir <= '0;
    end else begin
      case (st)
        ST_OFF:     if (start) st <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ack) begin
            ir <= mem_rdata;
            st <= ST_DECODE;
          end
        end
        ST_DECODE:  st <= dec_next;
        ST_OPERAND: if (mem_ack) st <= ST_FETCH;
        ST_EXEC:    st <= ST_FETCH;
        ST_HALT:    st <= ST_HALT;
        default:    st <= ST_OFF;
      endcase
    end
  end

  always_comb begin
    power      = 1'b1;
    stop_en    = 1'b1;
    mem_req    = 1'b0;
    branch_en  = 1'b0;
    branch_pc  = '0;
    exec_valid = 1'b0;
    halted     = 1'b0;
    case (st)
      ST_OFF:   power = 1'b0;
      ST_FETCH: begin
        mem_req = 1'b1;
        stop_en = ~mem_ack;
      end
      ST_OPERAND: begin
        mem_req = 1'b1;
        stop_en = ~mem_ack;
        // untaken BZ still advances the PC past its operand byte
        if (mem_ack && taken) begin
          branch_en = 1'b1;
          branch_pc = mem_rdata;
        end
      end
      ST_EXEC:  exec_valid = 1'b1;
      ST_HALT:  halted = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench: sequencer plus a PC register model and a wait-state memory model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       zero_flag = 1'b0;
  logic [7:0] pc = 8'h00;
  logic       mem_req, mem_ack, power, stop_en, branch_en, exec_valid, halted;
  logic [7:0] mem_addr, mem_rdata, branch_pc, ir;
  logic [2:0] state;

  logic [7:0] mem [256];
  int         wait_states = 0;
  int         cnt = 0;
  logic       ack_force = 1'b0;

  int passes = 0;
  int checks = 0;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pc         (pc),
    .zero_flag  (zero_flag),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .power      (power),
    .stop_en    (stop_en),
    .branch_en  (branch_en),
    .branch_pc  (branch_pc),
    .ir         (ir),
    .exec_valid (exec_valid),
    .halted     (halted),
    .state      (state)
  );

  always #5 clk = ~clk;

  // program counter block driven by the sequencer
  always_ff @(posedge clk) begin
    if (!power)         pc <= 8'h00;
    else if (stop_en)   pc <= pc;
    else if (branch_en) pc <= branch_pc;
    else                pc <= pc + 8'd1;
  end

  // memory: acks after wait_states idle request cycles
  always_ff @(posedge clk) begin
    if (mem_req && !mem_ack) cnt <= cnt + 1;
    else                     cnt <= 0;
  end
  assign mem_ack   = ack_force | (mem_req && (cnt == wait_states));
  assign mem_rdata = mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: got %02h expected %02h", tag, obs, exp);
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
  endtask

  task automatic chks(input string tag, input logic [2:0] obs, input state_t exp);
    checks = checks + 1;
    assert (obs === exp) passes = passes + 1;
    else $error("FAIL %s: got state %0d expected %0d", tag, obs, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  // reset, one idle edge in OFF, then a start pulse; ends in FETCH with pc=0
  task automatic boot();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // reset values and the NOP stream 00,00
    clear_mem();
    wait_states = 0;
    rst = 1'b1;
    tick();
    chkb("rst_power", power, 1'b0);
    chkb("rst_stop_en", stop_en, 1'b1);
    chkb("rst_branch_en", branch_en, 1'b0);
    chk ("rst_branch_pc", branch_pc, 8'h00);
    chkb("rst_mem_req", mem_req, 1'b0);
    chkb("rst_exec_valid", exec_valid, 1'b0);
    chkb("rst_halted", halted, 1'b0);
    chks("rst_state", state, ST_OFF);
    chk ("rst_ir", ir, 8'h00);
    tick();
    chk ("rst_pc", pc, 8'h00);
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chks("nop_state_f0", state, ST_FETCH);
    chk ("nop_pc_f0", pc, 8'h00);
    chkb("nop_req_f0", mem_req, 1'b1);
    tick();
    chks("nop_state_d0", state, ST_DECODE);
    chk ("nop_pc_d0", pc, 8'h01);
    chkb("nop_req_d0", mem_req, 1'b0);
    tick();
    chk ("nop_pc_f1", pc, 8'h01);
    chkb("nop_req_f1", mem_req, 1'b1);
    tick();
    chk ("nop_pc_d1", pc, 8'h02);

    // JMP 0x10
    clear_mem();
    mem[0] = 8'h40;
    mem[1] = 8'h10;
    boot();
    tick();
    chk ("jmp_ir", ir, 8'h40);
    chks("jmp_state_dec", state, ST_DECODE);
    tick();
    chks("jmp_state_opnd", state, ST_OPERAND);
    chkb("jmp_branch_en", branch_en, 1'b1);
    chk ("jmp_branch_pc", branch_pc, 8'h10);
    chkb("jmp_stop_en", stop_en, 1'b0);
    tick();
    chk ("jmp_pc", pc, 8'h10);
    chkb("jmp_branch_en_after", branch_en, 1'b0);
    chk ("jmp_branch_pc_after", branch_pc, 8'h00);

    // jump to 0xFF then wrap to 0x00 on the next fetch
    clear_mem();
    mem[0] = 8'h40;
    mem[1] = 8'hFF;
    boot();
    tick();
    tick();
    tick();
    chk ("wrap_pc_ff", pc, 8'hFF);
    tick();
    chk ("wrap_pc_00", pc, 8'h00);
    chks("wrap_state", state, ST_DECODE);

    // BZ at address 4 (preceded by NOP-class opcodes), taken then not taken
    for (int k = 0; k < 2; k++) begin
      clear_mem();
      mem[1] = 8'h80;
      mem[2] = 8'hA0;
      mem[3] = 8'hC0;
      mem[4] = 8'h60;
      mem[5] = 8'h20;
      zero_flag = (k == 0);
      boot();
      repeat (9) tick();
      chk ("bz_ir", ir, 8'h60);
      chk ("bz_pc_dec", pc, 8'h05);
      tick();
      chkb("bz_branch_en", branch_en, (k == 0));
      chkb("bz_stop_en", stop_en, 1'b0);
      tick();
      chk ("bz_pc", pc, (k == 0) ? 8'h20 : 8'h06);
    end
    zero_flag = 1'b0;

    // ALU with two wait states
    clear_mem();
    mem[0] = 8'h2A;
    wait_states = 2;
    boot();
    chks("alu_state_f", state, ST_FETCH);
    chkb("alu_stop_w0", stop_en, 1'b1);
    chk ("alu_pc_w0", pc, 8'h00);
    tick();
    chkb("alu_stop_w1", stop_en, 1'b1);
    chk ("alu_pc_w1", pc, 8'h00);
    tick();
    chkb("alu_stop_ack", stop_en, 1'b0);
    tick();
    chks("alu_state_dec", state, ST_DECODE);
    chk ("alu_ir", ir, 8'h2A);
    chkb("alu_exec_dec", exec_valid, 1'b0);
    chk ("alu_pc_dec", pc, 8'h01);
    tick();
    chkb("alu_exec", exec_valid, 1'b1);
    chkb("alu_stop_exec", stop_en, 1'b1);
    tick();
    chkb("alu_exec_after", exec_valid, 1'b0);
    chks("alu_state_next", state, ST_FETCH);
    chk ("alu_pc_next", pc, 8'h01);
    wait_states = 0;

    // HALT ignores start pulses, only reset leaves it
    clear_mem();
    mem[0] = 8'hE0;
    boot();
    tick();
    tick();
    chkb("halt_halted", halted, 1'b1);
    chks("halt_state", state, ST_HALT);
    for (int i = 0; i < 20; i++) begin
      start = (i % 3 == 0);
      tick();
      chk ("halt_pc_frozen", pc, 8'h01);
      chkb("halt_held", halted, 1'b1);
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
    chkb("halt_rst_halted", halted, 1'b0);
    chks("halt_rst_state", state, ST_OFF);
    tick();
    chk ("halt_rst_pc", pc, 8'h00);
    rst = 1'b0;

    // reset during an OPERAND wait, then a stale ack
    clear_mem();
    mem[0] = 8'h40;
    mem[1] = 8'h10;
    wait_states = 3;
    boot();
    repeat (3) tick();
    tick();
    tick();
    chks("late_state_opnd", state, ST_OPERAND);
    chkb("late_ack_wait", mem_ack, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ack_force = 1'b1;
    chks("late_state_off", state, ST_OFF);
    chkb("late_branch_en", branch_en, 1'b0);
    chk ("late_ir", ir, 8'h00);
    tick();
    ack_force = 1'b0;
    chks("late_state_off2", state, ST_OFF);
    chk ("late_pc", pc, 8'h00);
    chk ("late_ir2", ir, 8'h00);
    chkb("late_branch_en2", branch_en, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
